// File: rtl/sd4_pp_generator.sv
// Radix-4 (SD4/Booth) partial-product generator: nine signed act*wgt lanes in parallel,
// one recoded weight digit per cycle, valid/ready on both sides, one job in flight.
module sd4_pp_generator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PP_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*DATA_W-1:0]   act_in,
    input  logic [9*DATA_W-1:0]   wgt_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PP_W-1:0]       aligned_pp_0,
    output logic [PP_W-1:0]       aligned_pp_1,
    output logic [PP_W-1:0]       aligned_pp_2,
    output logic [PP_W-1:0]       aligned_pp_3,
    output logic [PP_W-1:0]       aligned_pp_4,
    output logic [PP_W-1:0]       aligned_pp_5,
    output logic [PP_W-1:0]       aligned_pp_6,
    output logic [PP_W-1:0]       aligned_pp_7,
    output logic [PP_W-1:0]       aligned_pp_8
);

    localparam int unsigned NUM_LANES = 9;
    localparam int unsigned NUM_DIG   = DATA_W / 2;
    localparam int unsigned CNT_W     = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W:0]     shamt;
    logic               accept;
    logic               last_dig;

    logic [DATA_W-1:0]  act_q  [NUM_LANES];
    logic [DATA_W-1:0]  wgt_q  [NUM_LANES];
    logic [PP_W-1:0]    acc_q  [NUM_LANES];
    logic [PP_W-1:0]    addend [NUM_LANES];

    assign accept   = in_valid & in_ready;
    assign last_dig = (cnt_q == CNT_W'(NUM_DIG - 1));
    assign shamt    = {cnt_q, 1'b0};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = CALC;
            CALC:    if (last_dig)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register; handshake flags decoded from the next state so they stay low in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    // Per-lane digit recode and aligned partial product
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [DATA_W:0]  wext;
        logic [2:0]       trip;
        logic [PP_W-1:0]  act_ext;
        logic [PP_W-1:0]  pp;

        assign wext    = {wgt_q[k], 1'b0};
        assign trip    = 3'(wext >> shamt);
        assign act_ext = PP_W'($signed(act_q[k]));

        always_comb begin
            pp = '0;
            case (trip)
                3'b001, 3'b010: pp = act_ext;
                3'b011:         pp = act_ext << 1;
                3'b100:         pp = -(act_ext << 1);
                3'b101, 3'b110: pp = -act_ext;
                default:        pp = '0;
            endcase
        end

        assign addend[k] = pp << shamt;
    end

    // Operand capture and accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                act_q[k] <= '0;
                wgt_q[k] <= '0;
                acc_q[k] <= '0;
            end
        end else if (accept) begin
            cnt_q <= '0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                act_q[k] <= act_in[k*DATA_W +: DATA_W];
                wgt_q[k] <= wgt_in[k*DATA_W +: DATA_W];
                acc_q[k] <= '0;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                acc_q[k] <= acc_q[k] + addend[k];
            end
        end
    end

    assign aligned_pp_0 = acc_q[0];
    assign aligned_pp_1 = acc_q[1];
    assign aligned_pp_2 = acc_q[2];
    assign aligned_pp_3 = acc_q[3];
    assign aligned_pp_4 = acc_q[4];
    assign aligned_pp_5 = acc_q[5];
    assign aligned_pp_6 = acc_q[6];
    assign aligned_pp_7 = acc_q[7];
    assign aligned_pp_8 = acc_q[8];

endmodule

// File: tb/tb_sd4_pp_generator.sv
// Bench for sd4_pp_generator: vector table, handshake corner sequences and a random
// run, all results cross-checked through an expected-result queue.
module tb_sd4_pp_generator;

    localparam int NV = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [71:0]   act_in;
    logic [71:0]   wgt_in;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   pp [9];
    logic [143:0]  all_pp;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    int n_drop   = 0;

    logic [143:0] sb [$];

    typedef struct {
        logic [71:0]  act;
        logic [71:0]  wgt;
        logic [143:0] exp;
    } vec_t;

    vec_t vt [NV];

    int ta [NV][9] = '{
        '{1, 1, 1, 1, 1, 1, 1, 1, 1},
        '{-3, -3, -3, -3, -3, -3, -3, -3, -3},
        '{-128, -128, 127, 127, -1, 0, 3, -7, 100},
        '{37, -45, 1, -1, 64, -64, 99, -100, 2},
        '{5, 5, 5, 5, 5, 5, 5, 5, 5}
    };
    int tw [NV][9] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8},
        '{0, 1, 2, 3, 4, 5, 6, 7, 8},
        '{-128, 127, 127, -128, -1, -128, -5, 9, -100},
        '{-1, -1, 0, 0, -1, -1, 2, -2, -1},
        '{-7, -7, -7, -7, -7, -7, -7, -7, -7}
    };
    int te [NV][9] = '{
        '{0, 1, 2, 3, 4, 5, 6, 7, 8},
        '{0, -3, -6, -9, -12, -15, -18, -21, -24},
        '{16384, -16256, 16129, -16256, 1, 0, -15, -63, -10000},
        '{-37, 45, 0, 0, -64, 64, 198, 200, -2},
        '{-35, -35, -35, -35, -35, -35, -35, -35, -35}
    };

    sd4_pp_generator #(.DATA_W(8), .PP_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .act_in       (act_in),
        .wgt_in       (wgt_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .aligned_pp_0 (pp[0]),
        .aligned_pp_1 (pp[1]),
        .aligned_pp_2 (pp[2]),
        .aligned_pp_3 (pp[3]),
        .aligned_pp_4 (pp[4]),
        .aligned_pp_5 (pp[5]),
        .aligned_pp_6 (pp[6]),
        .aligned_pp_7 (pp[7]),
        .aligned_pp_8 (pp[8])
    );

    assign all_pp = {pp[8], pp[7], pp[6], pp[5], pp[4], pp[3], pp[2], pp[1], pp[0]};

    always #5 clk = ~clk;

    function automatic logic [143:0] model(input logic [71:0] a, input logic [71:0] w);
        logic [143:0]      r;
        logic signed [7:0] sa;
        logic signed [7:0] sw;
        int                p;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            sa = a[k*8 +: 8];
            sw = w[k*8 +: 8];
            p  = int'(sa) * int'(sw);
            r[k*16 +: 16] = 16'(p);
        end
        return r;
    endfunction

    function automatic logic [71:0] rand_ops();
        logic [71:0] r;
        logic [7:0]  corner [4];
        corner[0] = 8'h80;
        corner[1] = 8'h7f;
        corner[2] = 8'h00;
        corner[3] = 8'hff;
        for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 7) == 0) r[k*8 +: 8] = corner[$urandom_range(0, 3)];
            else                           r[k*8 +: 8] = 8'($urandom);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back(model(act_in, wgt_in));
                n_push++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got result %h with no job pending, required none", all_pp);
                end else begin
                    n_pop++;
                    chk("sb_result", all_pp, sb.pop_front());
                end
            end
        end
    end

    task automatic wait_ov(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 144'(out_valid), 144'(1));
    endtask

    task automatic run_vec(input int i);
        int lat;
        @(posedge clk); #1;
        act_in    = vt[i].act;
        wgt_in    = vt[i].wgt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), 144'(in_ready), 144'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", i), 144'(lat), 144'(5));
        chk($sformatf("v%0d_pp", i), all_pp, vt[i].exp);
    endtask

    initial begin
        logic [71:0] a_act, a_wgt, b_act, b_wgt;
        logic        saw;
        int          n_acc;
        int          guard;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 9; k++) begin
                vt[i].act[k*8 +: 8]   = 8'(ta[i][k]);
                vt[i].wgt[k*8 +: 8]   = 8'(tw[i][k]);
                vt[i].exp[k*16 +: 16] = 16'(te[i][k]);
            end
        end

        // Reset with live, random inputs
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        act_in    = rand_ops();
        wgt_in    = rand_ops();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 144'(out_valid), 144'(0));
        chk("rst_in_ready", 144'(in_ready), 144'(0));
        chk("rst_pp", all_pp, 144'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("rel_in_ready_pre", 144'(in_ready), 144'(0));
        @(negedge clk);
        chk("rel_in_ready_edge1", 144'(in_ready), 144'(1));

        // Ramp, negative ramp, extremes, weights 0/-1
        for (int i = 0; i < 4; i++) run_vec(i);

        // Backpressure with in_valid held high
        a_act = rand_ops(); a_wgt = rand_ops();
        b_act = rand_ops(); b_wgt = rand_ops();
        @(posedge clk); #1;
        act_in    = a_act;
        wgt_in    = a_wgt;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        act_in = b_act;
        wgt_in = b_wgt;
        wait_ov("bp_a_valid");
        for (int j = 0; j < 3; j++) begin
            chk("bp_stable", all_pp, model(a_act, a_wgt));
            chk("bp_in_ready_busy", 144'(in_ready), 144'(0));
            @(negedge clk);
        end
        chk("bp_stable_last", all_pp, model(a_act, a_wgt));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 144'(in_ready), 144'(1));
        chk("bp_idle_out_valid", 144'(out_valid), 144'(0));
        @(negedge clk);
        chk("bp_b_accepted", 144'(in_ready), 144'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov("bp_b_valid");
        chk("bp_b_pp", all_pp, model(b_act, b_wgt));

        // Reset during digit 2 of a job
        @(posedge clk); #1;
        for (int k = 0; k < 9; k++) begin
            act_in[k*8 +: 8] = 8'(20 + k);
            wgt_in[k*8 +: 8] = 8'(100 - 3 * k);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pp", all_pp, 144'(0));
        chk("midrst_out_valid", 144'(out_valid), 144'(0));
        chk("midrst_in_ready", 144'(in_ready), 144'(0));
        n_drop += sb.size();
        sb.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        chk("midrst_no_valid", 144'(saw), 144'(0));
        run_vec(4);

        // Random traffic
        n_acc = 0;
        guard = 0;
        while (n_acc < 2000 && guard < 60000) begin
            @(posedge clk); #1;
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            act_in    = rand_ops();
            wgt_in    = rand_ops();
            @(negedge clk);
            if (in_valid && in_ready) n_acc++;
        end
        chk("rand_jobs", 144'(n_acc), 144'(2000));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", 144'(sb.size()), 144'(0));
        chk("sb_balance", 144'(n_pop), 144'(n_push - n_drop));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
